// File: rtl/reg_arb_pkg.sv
// Shared encodings for the register-bank arbiter: operation codes and FSM states.
package reg_arb_pkg;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_MOVE  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_SWAP  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_LOAD2 = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/reg_bank_arbiter_if.sv
// Bundle of requester, bank and debug signals around the arbiter.
// Handshake: a requester raises reqN with opN/dstN/srcN/dataN stable and keeps
// reqN high until it sees the one-cycle ackN pulse; it must drop reqN on the
// edge that samples ackN. The fields are only sampled in the granting cycle.
interface reg_bank_arbiter_if
    import reg_arb_pkg::*;
#(
    parameter int NREG = 4,
    parameter int W    = 32,
    parameter int IDXW = 2
);
    logic                req0, req1;
    logic [1:0]          op0, op1;
    logic [IDXW-1:0]     dst0, dst1;
    logic [IDXW-1:0]     src0, src1;
    logic [W-1:0]        data0, data1;
    logic [NREG*W-1:0]   q_flat;
    logic [NREG-1:0]     load;
    logic [W-1:0]        bus;
    logic                ack0, ack1;
    logic                busy;
    // Debug visibility of the controller FSM and arbitration history.
    state_t              state;
    logic                last_grant;

    modport slave (
        input  req0, req1, op0, op1, dst0, dst1, src0, src1, data0, data1, q_flat,
        output load, bus, ack0, ack1, busy, state, last_grant
    );

    modport master (
        output req0, req1, op0, op1, dst0, dst1, src0, src1, data0, data1, q_flat,
        input  load, bus, ack0, ack1, busy, state, last_grant
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. last_grant holds the index of the most
// recently granted requester; it resets to 1 so requester 0 wins first.
module rr_arb2 (
    input  logic       clk,
    input  logic       clear_n,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] grant,
    output logic       last_grant
);

    // Pick the single requester, or the one not granted last on contention.
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    // Remember who was served so the other side wins the next tie.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            last_grant <= 1'b1;
        end else if (|grant) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Shares an external register bank between two requesters and sequences
// write / clear / move / swap by driving one-hot load strobes and a shared bus.
// Every output is a register, computed from the next state.
module reg_bank_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NREG = 4,
    parameter int W    = 32,
    parameter int IDXW = 2
) (
    input  logic              clk,
    input  logic              clear_n,
    reg_bank_arbiter_if.slave rb
);

    state_t          state, state_n;
    logic [1:0]      op_q, op_n;
    logic [IDXW-1:0] dst_q, dst_n, src_q, src_n;
    logic [W-1:0]    data_q, data_n;
    logic [W-1:0]    tmp_a, tmp_a_n, tmp_b, tmp_b_n;
    logic            who_q, who_n;
    logic [NREG-1:0] load_q, load_n;
    logic [W-1:0]    bus_q, bus_n;
    logic            ack0_q, ack0_n, ack1_q, ack1_n, busy_q, busy_n;
    logic [1:0]      grant;
    logic            last_grant;
    logic [W-1:0]    q [NREG];

    rr_arb2 u_arb (
        .clk        (clk),
        .clear_n    (clear_n),
        .req        ({rb.req1, rb.req0}),
        .enable     (state == ST_IDLE),
        .grant      (grant),
        .last_grant (last_grant)
    );

    // Unpack the bank outputs so registers can be selected by index.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            q[i] = rb.q_flat[i*W +: W];
        end
    end

    // Next state, operation latch on grant, and source/destination capture in READ.
    always_comb begin
        state_n = state;
        op_n    = op_q;
        dst_n   = dst_q;
        src_n   = src_q;
        data_n  = data_q;
        who_n   = who_q;
        tmp_a_n = tmp_a;
        tmp_b_n = tmp_b;
        case (state)
            ST_IDLE: begin
                if (|grant) begin
                    who_n = grant[1];
                    if (grant[1]) begin
                        op_n   = rb.op1;
                        dst_n  = rb.dst1;
                        src_n  = rb.src1;
                        data_n = rb.data1;
                    end else begin
                        op_n   = rb.op0;
                        dst_n  = rb.dst0;
                        src_n  = rb.src0;
                        data_n = rb.data0;
                    end
                    state_n = (op_n == OP_WRITE || op_n == OP_CLEAR) ? ST_LOAD : ST_READ;
                end
            end
            ST_READ: begin
                tmp_a_n = q[src_q];
                tmp_b_n = q[dst_q];
                state_n = ST_LOAD;
            end
            ST_LOAD:  state_n = (op_q == OP_SWAP) ? ST_LOAD2 : ST_DONE;
            ST_LOAD2: state_n = ST_DONE;
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Output values for the cycle being entered; load/bus are quiet outside LOAD/LOAD2.
    always_comb begin
        load_n = '0;
        bus_n  = '0;
        ack0_n = 1'b0;
        ack1_n = 1'b0;
        busy_n = (state_n != ST_IDLE);
        case (state_n)
            ST_LOAD: begin
                load_n = NREG'(1) << dst_n;
                case (op_n)
                    OP_WRITE: bus_n = data_n;
                    OP_CLEAR: bus_n = '0;
                    default:  bus_n = tmp_a_n;
                endcase
            end
            ST_LOAD2: begin
                load_n = NREG'(1) << src_n;
                bus_n  = tmp_b_n;
            end
            ST_DONE: begin
                ack0_n = !who_n;
                ack1_n = who_n;
            end
            default: ;
        endcase
    end

    // State, latched operation and registered outputs; reset aborts without ack.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state  <= ST_IDLE;
            op_q   <= '0;
            dst_q  <= '0;
            src_q  <= '0;
            data_q <= '0;
            who_q  <= 1'b0;
            tmp_a  <= '0;
            tmp_b  <= '0;
            load_q <= '0;
            bus_q  <= '0;
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_n;
            op_q   <= op_n;
            dst_q  <= dst_n;
            src_q  <= src_n;
            data_q <= data_n;
            who_q  <= who_n;
            tmp_a  <= tmp_a_n;
            tmp_b  <= tmp_b_n;
            load_q <= load_n;
            bus_q  <= bus_n;
            ack0_q <= ack0_n;
            ack1_q <= ack1_n;
            busy_q <= busy_n;
        end
    end

    assign rb.load       = load_q;
    assign rb.bus        = bus_q;
    assign rb.ack0       = ack0_q;
    assign rb.ack1       = ack1_q;
    assign rb.busy       = busy_q;
    assign rb.state      = state;
    assign rb.last_grant = last_grant;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Bench for reg_bank_arbiter: owns the register bank, drives two requesters,
// and predicts per-cycle outputs from an operation-level model.
module tb_reg_bank_arbiter;
  import reg_arb_pkg::*;

  localparam int NREG = 4;
  localparam int W    = 32;
  localparam int IDXW = 2;

  typedef struct packed {
    logic [NREG-1:0] load;
    logic [W-1:0]    bus;
    logic            ack0;
    logic            ack1;
    logic            busy;
  } cyc_t;

  logic clk;
  logic clear_n;

  reg_bank_arbiter_if #(.NREG(NREG), .W(W), .IDXW(IDXW)) rb ();

  reg_bank_arbiter #(.NREG(NREG), .W(W), .IDXW(IDXW)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .rb      (rb)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- external bank ----------------
  logic [W-1:0] bank [NREG];
  always @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (rb.load[i]) bank[i] <= rb.bus;
    end
  end
  assign rb.q_flat = {bank[3], bank[2], bank[1], bank[0]};

  // ---------------- scoreboard ----------------
  cyc_t         exp_q[$];
  logic [W-1:0] mbank [NREG];
  logic         m_last;
  bit           idle_cycle = 1'b1;
  int           n_checks = 0;
  int           n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cyc_t mk(input logic [NREG-1:0] l, input logic [W-1:0] b,
                              input logic a0, input logic a1, input logic bz);
    cyc_t c;
    c.load = l; c.bus = b; c.ack0 = a0; c.ack1 = a1; c.busy = bz;
    return c;
  endfunction

  function automatic logic [NREG-1:0] oh(input logic [IDXW-1:0] i);
    logic [NREG-1:0] one;
    one = 1;
    return one << i;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_last = 1'b1;
    idle_cycle = 1'b1;
  endtask

  // Model: on an idle cycle with a request, choose the winner and schedule the
  // whole visible output sequence of that operation, then apply its effect.
  logic            m_w;
  logic [1:0]      m_op;
  logic [IDXW-1:0] m_dst, m_src;
  logic [W-1:0]    m_data, m_a, m_b;
  cyc_t            m_done;
  always @(posedge clk) begin
    if (clear_n && idle_cycle && (rb.req0 || rb.req1)) begin
      m_w = (rb.req0 && rb.req1) ? !m_last : rb.req1;
      m_last = m_w;
      if (m_w) begin
        m_op = rb.op1; m_dst = rb.dst1; m_src = rb.src1; m_data = rb.data1;
      end else begin
        m_op = rb.op0; m_dst = rb.dst0; m_src = rb.src0; m_data = rb.data0;
      end
      m_done = mk('0, '0, !m_w, m_w, 1'b1);
      m_a = mbank[m_src];
      m_b = mbank[m_dst];
      case (m_op)
        OP_WRITE: begin
          exp_q.push_back(mk(oh(m_dst), m_data, 0, 0, 1));
          exp_q.push_back(m_done);
          mbank[m_dst] = m_data;
        end
        OP_CLEAR: begin
          exp_q.push_back(mk(oh(m_dst), '0, 0, 0, 1));
          exp_q.push_back(m_done);
          mbank[m_dst] = '0;
        end
        OP_MOVE: begin
          exp_q.push_back(mk('0, '0, 0, 0, 1));
          exp_q.push_back(mk(oh(m_dst), m_a, 0, 0, 1));
          exp_q.push_back(m_done);
          mbank[m_dst] = m_a;
        end
        default: begin
          exp_q.push_back(mk('0, '0, 0, 0, 1));
          exp_q.push_back(mk(oh(m_dst), m_a, 0, 0, 1));
          exp_q.push_back(mk(oh(m_src), m_b, 0, 0, 1));
          exp_q.push_back(m_done);
          mbank[m_dst] = m_a;
          mbank[m_src] = m_b;
        end
      endcase
    end
  end

  // Compare process: every cycle, outputs must equal the scheduled entry (or all-quiet).
  cyc_t c_exp, c_act;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      c_exp = exp_q.pop_front();
      idle_cycle = 1'b0;
    end else begin
      c_exp = '0;
      idle_cycle = 1'b1;
    end
    c_act = mk(rb.load, rb.bus, rb.ack0, rb.ack1, rb.busy);
    chk("cycle_outputs", 64'(c_act), 64'(c_exp));
  end

  // ---------------- driver tasks ----------------
  logic [NREG-1:0] log_load [8];
  logic [W-1:0]    log_bus [8];

  task automatic raise(input int r, input logic [1:0] op, input logic [IDXW-1:0] dst,
                       input logic [IDXW-1:0] src, input logic [W-1:0] data);
    if (r == 0) begin
      rb.op0 = op; rb.dst0 = dst; rb.src0 = src; rb.data0 = data; rb.req0 = 1'b1;
    end else begin
      rb.op1 = op; rb.dst1 = dst; rb.src1 = src; rb.data1 = data; rb.req1 = 1'b1;
    end
  endtask

  // Issue one operation alone and measure cycles from the sampling edge to ack.
  task automatic issue(input int r, input logic [1:0] op, input logic [IDXW-1:0] dst,
                       input logic [IDXW-1:0] src, input logic [W-1:0] data,
                       input int exp_lat);
    int  n;
    bit  done;
    @(negedge clk);
    raise(r, op, dst, src, data);
    n = 0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (n > 0 || rb.busy) begin
        n++;
        if (n < 8) begin
          log_load[n] = rb.load;
          log_bus[n] = rb.bus;
        end
        if ((r == 0 && rb.ack0) || (r == 1 && rb.ack1)) begin
          done = 1'b1;
          if (r == 0) rb.req0 = 1'b0; else rb.req1 = 1'b0;
        end
      end
    end
    chk("ack_seen", 64'(done), 64'(1));
    chk("latency", 64'(n), 64'(exp_lat));
    if (!done) begin
      rb.req0 = 1'b0;
      rb.req1 = 1'b0;
    end
  endtask

  // ---------------- main sequence ----------------
  int  order [6];
  int  n_acks;
  bit  found;
  bit  drained;

  initial begin
    clear_n = 1'b1;
    rb.req0 = 0; rb.req1 = 0;
    rb.op0 = 0; rb.op1 = 0; rb.dst0 = 0; rb.dst1 = 0;
    rb.src0 = 0; rb.src1 = 0; rb.data0 = 0; rb.data1 = 0;
    #1 clear_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_load", 64'(rb.load), 64'(0));
    chk("reset_bus", 64'(rb.bus), 64'(0));
    chk("reset_acks", 64'({rb.ack0, rb.ack1}), 64'(0));
    chk("reset_busy", 64'(rb.busy), 64'(0));
    #2 clear_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_release", 64'({rb.load, rb.bus, rb.busy}), 64'(0));

    // Clear every register (data is ignored by clear).
    for (int i = 0; i < NREG; i++) issue(0, OP_CLEAR, IDXW'(i), 0, $urandom, 2);
    for (int i = 0; i < NREG; i++) chk("cleared", 64'(bank[i]), 64'(0));

    // Write.
    issue(0, OP_WRITE, 2, 0, 32'hDEAD_BEEF, 2);
    chk("write_load", 64'(log_load[1]), 64'(4'b0100));
    chk("write_bus", 64'(log_bus[1]), 64'(32'hDEAD_BEEF));
    chk("write_r2", 64'(bank[2]), 64'(32'hDEAD_BEEF));

    // Move R1 -> R3 from requester 1.
    issue(0, OP_WRITE, 1, 0, 32'h1234_5678, 2);
    issue(1, OP_MOVE, 3, 1, 32'hFFFF_FFFF, 3);
    chk("move_load", 64'(log_load[2]), 64'(4'b1000));
    chk("move_bus", 64'(log_bus[2]), 64'(32'h1234_5678));
    chk("move_r3", 64'(bank[3]), 64'(32'h1234_5678));
    chk("move_r1", 64'(bank[1]), 64'(32'h1234_5678));

    // Swap R0 <-> R3.
    issue(0, OP_WRITE, 0, 0, 32'hAAAA_0000, 2);
    issue(0, OP_WRITE, 3, 0, 32'h0000_BBBB, 2);
    issue(0, OP_SWAP, 0, 3, 32'h0, 4);
    chk("swap_load1", 64'(log_load[2]), 64'(4'b0001));
    chk("swap_bus1", 64'(log_bus[2]), 64'(32'h0000_BBBB));
    chk("swap_load2", 64'(log_load[3]), 64'(4'b1000));
    chk("swap_bus2", 64'(log_bus[3]), 64'(32'hAAAA_0000));
    chk("swap_r0", 64'(bank[0]), 64'(32'h0000_BBBB));
    chk("swap_r3", 64'(bank[3]), 64'(32'hAAAA_0000));

    // Degenerate move and swap on one register leave it unchanged.
    issue(1, OP_MOVE, 2, 2, 32'h0, 3);
    chk("move_same_r2", 64'(bank[2]), 64'(32'hDEAD_BEEF));
    issue(0, OP_SWAP, 2, 2, 32'h0, 4);
    chk("swap_same_r2", 64'(bank[2]), 64'(32'hDEAD_BEEF));

    // Randomized traffic from both requesters.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (rb.req0 && rb.ack0) rb.req0 = 1'b0;
      else if (!rb.req0 && $urandom_range(0, 3) == 0)
        raise(0, 2'($urandom_range(0, 3)), IDXW'($urandom_range(0, 3)),
              IDXW'($urandom_range(0, 3)), $urandom);
      if (rb.req1 && rb.ack1) rb.req1 = 1'b0;
      else if (!rb.req1 && $urandom_range(0, 3) == 0)
        raise(1, 2'($urandom_range(0, 3)), IDXW'($urandom_range(0, 3)),
              IDXW'($urandom_range(0, 3)), $urandom);
    end
    drained = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rb.ack0) rb.req0 = 1'b0;
      if (rb.ack1) rb.req1 = 1'b0;
      if (!rb.req0 && !rb.req1 && !rb.busy) begin
        drained = 1'b1;
        break;
      end
    end
    chk("drain", 64'(drained), 64'(1));
    @(negedge clk);
    for (int i = 0; i < NREG; i++) chk("bank_vs_model", 64'(bank[i]), 64'(mbank[i]));

    // Abort a swap R1 <-> R2 during its second load.
    issue(0, OP_WRITE, 1, 0, 32'h1111_1111, 2);
    issue(0, OP_WRITE, 2, 0, 32'h2222_2222, 2);
    @(negedge clk);
    raise(0, OP_SWAP, 1, 2, 32'h0);
    found = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rb.load == 4'b0100) begin
        found = 1'b1;
        break;
      end
    end
    chk("abort_reached_load2", 64'(found), 64'(1));
    #1 clear_n = 1'b0;
    model_reset();
    mbank[2] = 32'h2222_2222;
    #1;
    chk("abort_load", 64'(rb.load), 64'(0));
    chk("abort_bus", 64'(rb.bus), 64'(0));
    chk("abort_busy", 64'(rb.busy), 64'(0));
    rb.req0 = 1'b0;
    repeat (2) @(negedge clk);
    #2 clear_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_idle", 64'({rb.busy, rb.ack0, rb.ack1}), 64'(0));
    chk("abort_r1_updated", 64'(bank[1]), 64'(32'h2222_2222));
    chk("abort_r2_kept", 64'(bank[2]), 64'(32'h2222_2222));

    // Contention right after reset: requesters alternate starting with 0.
    @(negedge clk);
    raise(0, OP_WRITE, 0, 0, $urandom);
    raise(1, OP_WRITE, 3, 0, $urandom);
    n_acks = 0;
    for (int k = 0; k < 60 && n_acks < 6; k++) begin
      @(negedge clk);
      if (rb.ack0 && n_acks < 6) begin
        order[n_acks] = 0; n_acks++; rb.req0 = 1'b0;
      end else if (!rb.req0 && n_acks < 5) begin
        raise(0, OP_WRITE, IDXW'($urandom_range(0, 3)), 0, $urandom);
      end
      if (rb.ack1 && n_acks < 6) begin
        order[n_acks] = 1; n_acks++; rb.req1 = 1'b0;
      end else if (!rb.req1 && n_acks < 5) begin
        raise(1, OP_WRITE, IDXW'($urandom_range(0, 3)), 0, $urandom);
      end
    end
    chk("contention_acks", 64'(n_acks), 64'(6));
    for (int i = 0; i < 6; i++) chk("contention_order", 64'(order[i]), 64'(i % 2));
    rb.req0 = 1'b0;
    rb.req1 = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < NREG; i++) chk("bank_vs_model_end", 64'(bank[i]), 64'(mbank[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
